// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared constants, mode enum and length-width helper for pattern_detector
package pattern_detector_pkg;

    localparam logic [7:0] DEF_PAT = 8'h12;
    localparam int         DEF_LEN = 5;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } mode_e;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pd_match_counter.sv
// rtl/pd_match_counter.sv - saturating match counter with clear priority
module pd_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial bit-pattern detector with programmable pattern and overlap mode
// Match counter is built only when PATTERN_DETECTOR_CNT_EN is defined; otherwise match_cnt reads 0.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT),
    parameter int               RST_LEN = DEF_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in,
    input  logic                      in_valid,
    input  logic                      overlap,
    input  logic                      pat_load,
    input  logic [PAT_W-1:0]          pat_data,
    input  logic [len_w(PAT_W)-1:0]   pat_len,
    input  logic                      cnt_clr,
    output logic                      match,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [len_w(PAT_W)-1:0]   fill
);

    localparam int LW = len_w(PAT_W);
    typedef logic [LW-1:0] len_t;
    localparam len_t MIN_LEN = LW'(2);
    localparam len_t MAX_LEN = LW'(PAT_W);

    function automatic len_t clamp_len(input len_t l);
        if (l < MIN_LEN)      return MIN_LEN;
        else if (l > MAX_LEN) return MAX_LEN;
        else                  return l;
    endfunction

    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
    len_t             len_q, len_d, fill_q, fill_d;
    logic             match_q, match_d;

    logic [PAT_W-1:0] hist_sh, len_mask;
    len_t             fill_inc;
    logic             accept, hit;
    mode_e            mode;

    assign mode = mode_e'(overlap);

    // Only the low len bits take part in the compare; stored bits above are don't-care.
    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (len_t'(i) < len_q);
        end
    end

    always_comb begin
        hist_sh  = (hist_q << 1) | {{(PAT_W-1){1'b0}}, in};
        fill_inc = (fill_q == MAX_LEN) ? fill_q : fill_q + len_t'(1);
        accept   = in_valid & ~pat_load;
        hit      = accept && (fill_inc >= len_q) && (((hist_sh ^ pat_q) & len_mask) == '0);

        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        match_d = 1'b0;

        if (pat_load) begin
            pat_d  = pat_data;
            len_d  = clamp_len(pat_len);
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            match_d = hit;
            if (hit && (mode == NON_OVERLAP)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_sh;
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= RST_PAT;
            len_q   <= clamp_len(LW'(RST_LEN));
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
    assign fill  = fill_q;

`ifdef PATTERN_DETECTOR_CNT_EN
    pd_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_q),
        .clr   (cnt_clr),
        .count (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - randomized self-checking bench for pattern_detector against a queue-based model
module tb_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PATTERN_DETECTOR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, in_b, in_valid, overlap, pat_load, cnt_clr;
    logic [PAT_W-1:0] pat_data;
    logic [LW-1:0]    pat_len;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [LW-1:0]    fill;

    pattern_detector #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_b),
        .in_valid  (in_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_hits = 0;

    bit         hist_m[$];
    logic [7:0] pat_m;
    int         len_m;
    bit         match_m;
    bit         prev_match;
    int         cnt_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit tail_matches();
        if (hist_m.size() < len_m) return 1'b0;
        for (int i = 0; i < len_m; i++) begin
            if (hist_m[hist_m.size() - 1 - i] != pat_m[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: the accepted-bit history as a queue, matched against the pattern tail.
    always @(posedge clk) begin
        prev_match = match_m;
        if (rst) begin
            pat_m   = 8'h12;
            len_m   = 5;
            hist_m.delete();
            match_m = 1'b0;
            cnt_m   = 0;
        end else begin
            if (CNT_EN && cnt_clr)                        cnt_m = 0;
            else if (CNT_EN && prev_match && cnt_m < CMAX) cnt_m = cnt_m + 1;
            match_m = 1'b0;
            if (pat_load) begin
                pat_m = pat_data;
                len_m = (pat_len < 2) ? 2 : (pat_len > PAT_W) ? PAT_W : int'(pat_len);
                hist_m.delete();
            end else if (in_valid) begin
                hist_m.push_back(in_b);
                if (hist_m.size() > PAT_W) void'(hist_m.pop_front());
                if (tail_matches()) begin
                    match_m = 1'b1;
                    if (!overlap) hist_m.delete();
                end
            end
        end
        #1;
        chk("match", match, match_m);
        chk("fill", fill, hist_m.size());
        chk("match_cnt", match_cnt, cnt_m);
        if (match === 1'b1) dut_hits++;
    end

    task automatic defaults();
        rst = 0; in_valid = 0; in_b = 0; pat_load = 0; cnt_clr = 0;
    endtask

    task automatic send(input bit b);
        @(negedge clk);
        defaults();
        in_valid = 1; in_b = b;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            defaults();
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        defaults();
        rst = 1;
    endtask

    task automatic load(input logic [7:0] d, input logic [LW-1:0] l);
        @(negedge clk);
        defaults();
        pat_load = 1; pat_data = d; pat_len = l;
    endtask

    int h;

    initial begin
        rst = 1; in_valid = 0; in_b = 0; pat_load = 0; cnt_clr = 0;
        overlap = 1; pat_data = '0; pat_len = '0;
        @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);

        h = dut_hits;
        send_bits(32'b10010010010, 11); gap(2);
        chk("ovl_hits", dut_hits - h, 3);
        chk("ovl_cnt", match_cnt, CNT_EN ? 3 : 0);

        do_rst(); overlap = 0;
        h = dut_hits;
        send_bits(32'b10010010010, 11); gap(2);
        chk("novl_hits", dut_hits - h, 2);
        chk("novl_cnt", match_cnt, CNT_EN ? 2 : 0);

        overlap = 1;
        load(8'hA5, 4'd8);
        h = dut_hits;
        send_bits(32'hA5A5, 16); gap(2);
        chk("a5_hits", dut_hits - h, 2);

        load(8'h01, 4'd1);
        h = dut_hits;
        send_bits(32'b0101, 4); gap(2);
        chk("clamp_hits", dut_hits - h, 2);

        load(8'h12, 4'd5);
        h = dut_hits;
        send_bits(32'b1001, 4); gap(3); send(0); gap(2);
        chk("gap_hits", dut_hits - h, 1);

        do_rst();
        send_bits(32'b1001, 4); do_rst(); send(0); gap(1);
        h = dut_hits;
        gap(1);
        chk("rst_mid_match", match, 0);
        chk("rst_mid_fill", fill, 1);

        load(8'h01, 4'd2);
        for (int i = 0; i < 20; i++) send_bits(32'b01, 2);
        gap(2);
        chk("sat_cnt", match_cnt, CNT_EN ? CMAX : 0);

        send(0); send(1);
        @(negedge clk);
        defaults();
        chk("pre_clr_match", match, 1);
        cnt_clr = 1; in_valid = 1; in_b = 0;
        gap(1);
        chk("clr_cnt", match_cnt, 0);

        send_bits(32'b010, 3);
        @(negedge clk);
        defaults();
        pat_load = 1; pat_data = 8'h12; pat_len = 4'd5; in_valid = 1; in_b = 1;
        @(negedge clk);
        defaults();
        chk("load_fill", fill, 0);
        chk("load_match", match, 0);

        repeat (4000) begin
            @(negedge clk);
            defaults();
            in_valid = ($urandom_range(0, 99) < 75);
            in_b     = 1'($urandom);
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            if ($urandom_range(0, 79) == 0) begin
                pat_load = 1;
                pat_data = 8'($urandom);
                pat_len  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                                       : LW'($urandom_range(1, 5));
            end
            cnt_clr = ($urandom_range(0, 63) == 0);
            rst     = ($urandom_range(0, 599) == 0);
        end
        gap(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
